// File: rtl/spi_cmd_master.sv
// SPI mode-0 initiator for the two-byte register-access frame: a header byte {rw, 0, addr}
// followed by a data byte. Returns the byte captured during the data byte, or 0x00 for writes.
module spi_cmd_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    typedef struct packed {
        logic       rw;
        logic       rsvd;
        logic [5:0] addr;
        logic [7:0] data;
    } frame_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [14:0]      tx_sr;
    logic [7:0]       rx_sr;
    logic             rw_q;
    frame_t           frame;

    logic accept, div_done, last_bit;
    logic sclk_rise, sclk_fall, hold_done, gap_done;

    always_comb begin
        frame.rw   = req_rw;
        frame.rsvd = 1'b0;
        frame.addr = req_addr;
        frame.data = req_rw ? req_wdata : 8'h00;
    end

    assign accept    = req_valid & req_ready & (state == IDLE);
    assign div_done  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt == 4'd15);
    // The SETUP->SHIFT transition supplies the first rising edge; later ones come from
    // the end of each low half, until all 16 have been issued.
    assign sclk_rise = div_done & ((state == SETUP) | ((state == SHIFT) & ~sclk & ~last_bit));
    assign sclk_fall = div_done & (state == SHIFT) & sclk;
    assign hold_done = div_done & (state == HOLD);
    assign gap_done  = div_done & (state == GAP);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (div_done) state_d = SHIFT;
            SHIFT:   if (div_done && !sclk && last_bit) state_d = HOLD;
            HOLD:    if (div_done) state_d = GAP;
            GAP:     if (div_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div_cnt <= '0;
        else if (state == IDLE || state_d != state || div_done)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bit_cnt <= 4'd0;
        else if (state == SETUP)
            bit_cnt <= 4'd0;
        else if (sclk_rise)
            bit_cnt <= bit_cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= 8'h00;
            rw_q      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                rw_q      <= req_rw;
                tx_sr     <= frame[14:0];
                mosi      <= frame.rw;
                cs_n      <= 1'b0;
                req_ready <= 1'b0;
                busy      <= 1'b1;
            end
            if (sclk_rise) begin
                sclk  <= 1'b1;
                rx_sr <= {rx_sr[6:0], miso};
            end
            // After the final falling edge the shifter has run dry, so mosi settles to 0.
            if (sclk_fall) begin
                sclk  <= 1'b0;
                tx_sr <= {tx_sr[13:0], 1'b0};
                mosi  <= last_bit ? 1'b0 : tx_sr[14];
            end
            if (hold_done) begin
                cs_n      <= 1'b1;
                rsp_valid <= 1'b1;
                rsp_rdata <= rw_q ? 8'h00 : rx_sr;
            end
            if (gap_done) begin
                req_ready <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

endmodule
